// File: rtl/ram_wb_arbiter_b3.sv
// Two-master Wishbone B3 round-robin arbiter in front of a single B3 slave.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module ram_wb_arbiter_b3 #(
  parameter int unsigned dw      = 32,
  parameter int unsigned aw      = 32,
  parameter int unsigned timeout = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  // master 0
  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [1:0]    m0_bte_i,
  input  logic [2:0]    m0_cti_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  output logic [dw-1:0] m0_dat_o,
  // master 1
  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [1:0]    m1_bte_i,
  input  logic [2:0]    m1_cti_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  output logic [dw-1:0] m1_dat_o,
  // slave
  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic [1:0]    s_bte_o,
  output logic [2:0]    s_cti_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,
  input  logic [dw-1:0] s_dat_i,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e     state_q;
  logic [1:0] gnt_q;
  logic       last_q;
  logic       req_cyc;
  logic       req_stb;
  logic       to_hit;

  // Grant is held for as long as the owner keeps cyc high; hand-over needs no idle cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= StGnt0;
            gnt_q   <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= StGnt1;
            gnt_q   <= 2'b10;
          end
        end
        StGnt0: begin
          if (!m0_cyc_i) begin
            last_q <= 1'b0;
            if (m1_cyc_i) begin
              state_q <= StGnt1;
              gnt_q   <= 2'b10;
            end else begin
              state_q <= StIdle;
              gnt_q   <= 2'b00;
            end
          end
        end
        StGnt1: begin
          if (!m1_cyc_i) begin
            last_q <= 1'b1;
            if (m0_cyc_i) begin
              state_q <= StGnt0;
              gnt_q   <= 2'b01;
            end else begin
              state_q <= StIdle;
              gnt_q   <= 2'b00;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_bte_o = '0;
    s_cti_o = '0;
    s_we_o  = 1'b0;
    req_cyc = 1'b0;
    req_stb = 1'b0;
    unique case (gnt_q)
      2'b01: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_bte_o = m0_bte_i;
        s_cti_o = m0_cti_i;
        s_we_o  = m0_we_i;
        req_cyc = m0_cyc_i;
        req_stb = m0_stb_i;
      end
      2'b10: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_bte_o = m1_bte_i;
        s_cti_o = m1_cti_i;
        s_we_o  = m1_we_i;
        req_cyc = m1_cyc_i;
        req_stb = m1_stb_i;
      end
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       term;

  assign term   = s_ack_i | s_err_i | s_rty_i;
  assign to_hit = req_stb && (cnt_q == 8'(timeout));

  // Counts stalled strobe cycles of the current owner; idle or released grant clears it.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cnt_q <= 8'd0;
    end else if (!req_cyc || term || to_hit) begin
      cnt_q <= 8'd0;
    end else if (req_stb) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  assign s_cyc_o = req_cyc;
  assign s_stb_o = req_stb & ~to_hit;
  assign gnt_o   = gnt_q;

  assign m0_ack_o = s_ack_i & gnt_q[0];
  assign m0_err_o = (s_err_i | to_hit) & gnt_q[0];
  assign m0_rty_o = s_rty_i & gnt_q[0];
  assign m0_dat_o = s_dat_i;

  assign m1_ack_o = s_ack_i & gnt_q[1];
  assign m1_err_o = (s_err_i | to_hit) & gnt_q[1];
  assign m1_rty_o = s_rty_i & gnt_q[1];
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_ram_wb_arbiter_b3.sv
// Bench for ram_wb_arbiter_b3: directed scenarios plus randomized traffic against an ownership model.
module tb_ram_wb_arbiter_b3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] adr  [2];
  logic [DW-1:0] wdat [2];
  logic [3:0]    sel  [2];
  logic [1:0]    bte  [2];
  logic [2:0]    cti  [2];
  logic [1:0]    cyc, stb, we;
  logic          ack0, ack1, err0, err1, rty0, rty1;
  logic [DW-1:0] rdat0, rdat1;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat;
  logic [3:0]    s_sel;
  logic [1:0]    s_bte;
  logic [2:0]    s_cti;
  logic          s_cyc, s_stb, s_we;
  logic          s_ack, s_err, s_rty;
  logic [DW-1:0] s_rdat;
  logic [1:0]    gnt;

  int n_vec = 0;
  int n_err = 0;

  // Model state: who owns the bus (-1 = nobody), who had it last, stall count.
  int owner;
  bit last;
  int cnt;
  int unsigned len [2];

  always #5 clk = ~clk;

  ram_wb_arbiter_b3 #(.dw(DW), .aw(AW), .timeout(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_bte_i(bte[0]),
    .m0_cti_i(cti[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
    .m0_ack_o(ack0), .m0_err_o(err0), .m0_rty_o(rty0), .m0_dat_o(rdat0),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_bte_i(bte[1]),
    .m1_cti_i(cti[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
    .m1_ack_o(ack1), .m1_err_o(err1), .m1_rty_o(rty1), .m1_dat_o(rdat1),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel), .s_bte_o(s_bte), .s_cti_o(s_cti),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_rdat),
    .gnt_o(gnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last  = 1'b1;
    cnt   = 0;
  endtask

  function automatic bit timeout_now();
`ifdef ARB_TIMEOUT_EN
    return (owner >= 0) && stb[owner] && (cnt == int'(TO));
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model on a rising edge from the inputs present at that edge.
  task automatic model_update();
    int other;
    bit term;
    if (!rst_n) return;
    term = s_ack | s_err | s_rty;
`ifdef ARB_TIMEOUT_EN
    if (owner < 0 || !cyc[owner] || term || timeout_now()) cnt = 0;
    else if (stb[owner]) cnt = cnt + 1;
`endif
    if (owner < 0) begin
      if (cyc[0] && cyc[1]) owner = last ? 0 : 1;
      else if (cyc[0]) owner = 0;
      else if (cyc[1]) owner = 1;
    end else if (!cyc[owner]) begin
      last  = (owner == 1);
      other = 1 - owner;
      owner = cyc[other] ? other : -1;
    end
  endtask

  task automatic compare_model();
    bit       g;
    int       oi;
    bit       th;
    logic [1:0] eg;
    g  = (owner >= 0);
    oi = g ? owner : 0;
    th = timeout_now();
    eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    chk("gnt",   64'(gnt),   64'(eg));
    chk("s_cyc", 64'(s_cyc), 64'(g & cyc[oi]));
    chk("s_stb", 64'(s_stb), 64'(g & stb[oi] & ~th));
    chk("s_we",  64'(s_we),  64'(g & we[oi]));
    chk("s_adr", 64'(s_adr), g ? 64'(adr[oi]) : 64'd0);
    chk("s_dat", 64'(s_dat), g ? 64'(wdat[oi]) : 64'd0);
    chk("s_sel", 64'(s_sel), g ? 64'(sel[oi]) : 64'd0);
    chk("s_bte", 64'(s_bte), g ? 64'(bte[oi]) : 64'd0);
    chk("s_cti", 64'(s_cti), g ? 64'(cti[oi]) : 64'd0);
    chk("m0_ack", 64'(ack0), 64'(s_ack & (owner == 0)));
    chk("m1_ack", 64'(ack1), 64'(s_ack & (owner == 1)));
    chk("m0_err", 64'(err0), 64'((s_err | th) & (owner == 0)));
    chk("m1_err", 64'(err1), 64'((s_err | th) & (owner == 1)));
    chk("m0_rty", 64'(rty0), 64'(s_rty & (owner == 0)));
    chk("m1_rty", 64'(rty1), 64'(s_rty & (owner == 1)));
    chk("m0_dat", 64'(rdat0), 64'(s_rdat));
    chk("m1_dat", 64'(rdat1), 64'(s_rdat));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc_check();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle_all();
    for (int m = 0; m < 2; m++) begin
      adr[m] = '0; wdat[m] = '0; sel[m] = '0; bte[m] = '0; cti[m] = '0; len[m] = 0;
    end
    cyc = '0; stb = '0; we = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_rdat = '0;
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    model_reset();
    cyc_check();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    model_reset();
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_scyc", 64'(s_cyc), 64'd0);
    cyc_check();
    @(negedge clk);
    #1 rst_n = 1'b1;

    // m0 single read
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h100; cti[0] = 3'b000;
    cyc_check();
    chk("t1_lat_scyc", 64'(s_cyc), 64'd0);
    tick();
    s_ack = 1'b1; s_rdat = 32'hDEADBEEF;
    cyc_check();
    chk("t1_scyc", 64'(s_cyc), 64'd1);
    chk("t1_gnt", 64'(gnt), 64'd1);
    chk("t1_ack0", 64'(ack0), 64'd1);
    chk("t1_dat0", 64'(rdat0), 64'hDEADBEEF);
    chk("t1_ack1", 64'(ack1), 64'd0);
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b0;
    cyc_check();
    tick();
    sync_reset();

    // simultaneous requests
    tick();
    cyc = 2'b11; stb = 2'b11;
    cyc_check();
    tick();
    cyc_check();
    chk("t2_gnt0", 64'(gnt), 64'd1);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    tick();
    s_ack = 1'b1;
    cyc_check();
    chk("t2_handover", 64'(gnt), 64'd2);
    chk("t2_ack1", 64'(ack1), 64'd1);
    tick();
    cyc = 2'b00; stb = 2'b00; s_ack = 1'b0;
    cyc_check();
    tick();
    cyc = 2'b11; stb = 2'b11;
    cyc_check();
    tick();
    cyc_check();
    chk("t2_rr", 64'(gnt), 64'd1);
    tick();
    cyc = 2'b00; stb = 2'b00;
    cyc_check();

    // m1 wrap burst with m0 arriving mid-burst
    tick();
    cyc[1] = 1'b1; stb[1] = 1'b1; cti[1] = 3'b010; bte[1] = 2'b01;
    cyc_check();
    tick();
    cyc_check();
    chk("t3_gnt", 64'(gnt), 64'd2);
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      tick();
      s_ack = 1'b1;
      cti[1] = (b == 3) ? 3'b111 : 3'b010;
      cyc_check();
      chk("t3_hold", 64'(gnt), 64'd2);
      chk("t3_ack1", 64'(ack1), 64'd1);
    end
    tick();
    s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    cyc_check();
    chk("t3_release", 64'(gnt), 64'd2);
    tick();
    cyc_check();
    chk("t3_m0", 64'(gnt), 64'd1);

    // slave error on m1 write
    cyc[0] = 1'b0; stb[0] = 1'b0;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    tick();
    s_err = 1'b1;
    cyc_check();
    chk("t4_gnt", 64'(gnt), 64'd2);
    chk("t4_err1", 64'(err1), 64'd1);
    chk("t4_err0", 64'(err0), 64'd0);

    // async reset while m0 owns the bus
    tick();
    s_err = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    cyc_check();
    tick();
    cyc_check();
    chk("t5_gnt0", 64'(gnt), 64'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_async_scyc", 64'(s_cyc), 64'd0);
    chk("t5_async_sstb", 64'(s_stb), 64'd0);
    chk("t5_async_gnt", 64'(gnt), 64'd0);
    cyc[0] = 1'b0; stb[0] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    cyc_check();
    chk("t5_regnt", 64'(gnt), 64'd2);

`ifdef ARB_TIMEOUT_EN
    // watchdog: slave never answers m0
    cyc[1] = 1'b0; stb[1] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      cyc_check();
      chk("to_err0", 64'(err0), (i == 5) ? 64'd1 : 64'd0);
      chk("to_sstb", 64'(s_stb), (i == 5) ? 64'd0 : 64'd1);
      tick();
    end
    cyc_check();
    chk("to_restart", 64'(err0), 64'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (cyc[m]) begin
          if (len[m] == 0) cyc[m] = 1'b0;
          else len[m] = len[m] - 1;
        end else if ($urandom_range(0, 2) == 0) begin
          cyc[m] = 1'b1;
          len[m] = $urandom_range(0, 7);
        end
        stb[m]  = cyc[m] & ($urandom_range(0, 3) != 0);
        we[m]   = 1'($urandom);
        adr[m]  = $urandom;
        wdat[m] = $urandom;
        sel[m]  = 4'($urandom);
        bte[m]  = 2'($urandom);
        cti[m]  = 3'($urandom);
      end
      s_ack  = ($urandom_range(0, 3) == 0);
      s_err  = ($urandom_range(0, 15) == 0);
      s_rty  = ($urandom_range(0, 15) == 0);
      s_rdat = $urandom;
      if (i % 700 == 350) sync_reset();
      else cyc_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_wb_arbiter_b3.md
Name: ram_wb_arbiter_b3

Overview:
- Two-master Wishbone B3 arbiter that shares one B3 slave, such as the on-chip RAM, between two requesters (e.g. CPU instruction bus and debug/DMA bus).
- Round-robin grant, held for the whole cycle, so registered-feedback bursts are never split.
- Sits directly in front of the RAM slave port; purely a bus sequencer, no data storage.

Parameters:
- dw, 32, data width.
- aw, 32, address width.
- timeout, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN; legal range 1..255.

Ports:
- wb_clk_i  in  1  bus clock; everything on rising edge.
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
- mN_adr_i/mN_dat_i/mN_sel_i  in  aw/dw/4  master N (N=0,1) address, write data, byte selects.
- mN_bte_i/mN_cti_i  in  2/3  master N burst type and cycle type.
- mN_cyc_i/mN_stb_i/mN_we_i  in  1 each  master N cycle, strobe, write enable.
- mN_ack_o/mN_err_o/mN_rty_o  out  1 each  master N terminations.
- mN_dat_o  out  dw  master N read data.
- s_adr_o/s_dat_o/s_sel_o/s_bte_o/s_cti_o  out  aw/dw/4/2/3  slave request, muxed from the granted master.
- s_cyc_o/s_stb_o/s_we_o  out  1 each  slave control, zero when no grant.
- s_ack_i/s_err_i/s_rty_i  in  1 each  slave terminations.
- s_dat_i  in  dw  slave read data.
- gnt_o  out  2  one-hot current grant, debug visibility.

Behaviour:
- FSM states: IDLE, GNT0, GNT1. Grant is registered. Reset: IDLE, gnt_o=00, last=1 (so m0 wins the first tie).
- IDLE:
  - m0_cyc only -> GNT0; m1_cyc only -> GNT1.
  - Both -> grant the master that is not `last`.
  - Grant latency: 1 cycle from cyc assertion to slave s_cyc_o.
- GNTn:
  - Stay while mN_cyc_i=1, regardless of stb or cti, so bursts and RMW stay atomic.
  - On mN_cyc_i=0: if the other master has cyc=1, go directly to its GNT state (no idle cycle). Otherwise go to IDLE.
  - last<=N on every exit.
- Mux: s_* request outputs are combinational copies of the granted master's inputs. In IDLE, s_cyc_o=s_stb_o=s_we_o=0 and the other s_* outputs are 0.
- Returns:
  - mN_ack_o=s_ack_i&gnt_o[N]; err and rty are routed the same way.
  - mN_dat_o=s_dat_i for both masters (data is qualified by ack).
  - Non-granted master sees ack/err/rty=0 and simply waits.
- Reset mid-cycle: all outputs drop asynchronously to 0 and the FSM returns to IDLE. A master holding cyc through reset release is re-arbitrated from IDLE.
- Simultaneous release and new request by the same master (cyc low for exactly one cycle): that cycle is treated as a release; the other master wins if it is requesting.
- Grant never changes while the granted master's cyc_i=1.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With macro:
  - 8-bit counter increments each cycle that the granted stb=1 and s_ack_i|s_err_i|s_rty_i=0.
  - Counter clears on any termination, on grant change, and on reset.
  - When count==timeout: mN_err_o=1 for that cycle (also requires stb), s_stb_o is forced to 0 that cycle, and the counter clears.
  - Grant is still held until cyc drops.
- Without macro: no counter, and err is purely the routed s_err_i.

Test Plan:
- Reset, then m0 single read to 0x100 (cti=000) with slave data 0xDEADBEEF -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o=1 with m0_dat_o=0xDEADBEEF; gnt_o=01; m1_ack_o=0 throughout.
- m0 and m1 assert cyc in the same cycle after reset -> m0 granted first. On m0 release, gnt_o goes 01->10 with no IDLE cycle and m1 completes. The next simultaneous request grants m0 (last=1).
- m1 4-beat wrap burst (cti=010, bte=01) while m0 requests mid-burst -> gnt_o stays 10 for all 4 acks, through cti=111, until m1_cyc_i=0; then m0 is granted.
- Slave asserts s_err_i during m1 write -> m1_err_o=1 in the same cycle; m0_err_o=0.
- Assert wb_rst_n_i low mid-burst of m0 -> s_cyc_o, s_stb_o, gnt_o are 0 immediately, without waiting for a clock edge; after release with m1_cyc_i=1 only -> gnt_o=10 one cycle later.
- ARB_TIMEOUT_EN, timeout=4, slave never acks m0 -> m0_err_o=1 on the 5th stalled cycle (count==4), s_stb_o=0 that cycle, counter restarts.
